// File: rtl/rv_pipe_pkg.sv
// Shared definitions for the RV32I pipeline operand path: datapath defaults,
// forwarding-source encoding and the enums used by the ID/EX operand stage.
package rv_pipe_pkg;

  localparam int WIDTH_DEF = 32;
  localparam int AW_DEF    = 5;

  // fwd_src value meaning "operand came from the register file"
  localparam int FWD_RF = 0;

  typedef enum logic {
    OPB_RS2 = 1'b0,
    OPB_IMM = 1'b1
  } opb_sel_e;

  typedef enum logic {
    ST_EMPTY = 1'b0,
    ST_FULL  = 1'b1
  } stage_state_e;

endpackage

// File: rtl/opb_fwd_sel_resolve.sv
// Combinational rs2 forwarding resolver: the lowest-index matching slot wins,
// x0 always reads as zero, and the slot-0 hit is exported for hazard detection.
module fwd_resolve
  import rv_pipe_pkg::*;
#(
  parameter int WIDTH   = WIDTH_DEF,
  parameter int AW      = AW_DEF,
  parameter int NUM_FWD = 2,
  parameter int SW      = $clog2(NUM_FWD + 1)
) (
  input  logic [AW-1:0]            rs2_addr,
  input  logic [WIDTH-1:0]         rf_data,
  input  logic [NUM_FWD-1:0]       fwd_valid,
  input  logic [NUM_FWD-1:0]       fwd_wen,
  input  logic [NUM_FWD*AW-1:0]    fwd_addr,
  input  logic [NUM_FWD*WIDTH-1:0] fwd_data,
  output logic [WIDTH-1:0]         resolved,
  output logic [SW-1:0]            src,
  output logic                     slot0_hit
);

  logic [NUM_FWD-1:0] match;

  always_comb begin
    match = '0;
    for (int i = 0; i < NUM_FWD; i++) begin
      match[i] = fwd_valid[i] & fwd_wen[i] &
                 (fwd_addr[i*AW +: AW] == rs2_addr) & (rs2_addr != '0);
    end
  end

  // Walk oldest to newest so the newest matching slot overwrites the rest
  always_comb begin
    resolved  = rf_data;
    src       = SW'(FWD_RF);
    slot0_hit = match[0];
    for (int i = NUM_FWD - 1; i >= 0; i--) begin
      if (match[i]) begin
        resolved = fwd_data[i*WIDTH +: WIDTH];
        src      = SW'(i + 1);
      end
    end
    if (rs2_addr == '0) begin
      resolved = '0;
    end
  end

endmodule

// File: rtl/opb_fwd_sel.sv
// ID/EX operand-B stage: forwarding resolution, load-use stall detection,
// a single valid/ready pipeline register with flush, and a stall counter.
module opb_fwd_sel
  import rv_pipe_pkg::*;
#(
  parameter int WIDTH   = WIDTH_DEF,
  parameter int AW      = AW_DEF,
  parameter int NUM_FWD = 2,
  parameter int CNT_W   = 16
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           in_valid,
  output logic                           in_ready,
  input  logic [AW-1:0]                  rs2_addr,
  input  logic                           rs2_used,
  input  logic [WIDTH-1:0]               rf_data,
  input  logic [WIDTH-1:0]               imm,
  input  logic                           bsel,
  input  logic [NUM_FWD-1:0]             fwd_valid,
  input  logic [NUM_FWD-1:0]             fwd_wen,
  input  logic [NUM_FWD*AW-1:0]          fwd_addr,
  input  logic [NUM_FWD*WIDTH-1:0]       fwd_data,
  input  logic                           fwd_is_load,
  input  logic                           flush,
  output logic                           out_valid,
  input  logic                           out_ready,
  output logic [WIDTH-1:0]               op_b,
  output logic [WIDTH-1:0]               store_data,
  output logic [$clog2(NUM_FWD+1)-1:0]   fwd_src,
  output logic [CNT_W-1:0]               stall_cnt
);

  localparam int SW = $clog2(NUM_FWD + 1);

  logic [WIDTH-1:0] resolved_p0;
  logic [WIDTH-1:0] op_b_p0;
  logic [SW-1:0]    src_p0;
  logic             slot0_hit_p0;
  logic             hazard_p0;
  logic             xfer_p0;
  opb_sel_e         sel_p0;

  stage_state_e     state_p1;
  logic [WIDTH-1:0] op_b_p1;
  logic [WIDTH-1:0] store_data_p1;
  logic [SW-1:0]    src_p1;
  logic [CNT_W-1:0] stall_cnt_p1;

  fwd_resolve #(
    .WIDTH   (WIDTH),
    .AW      (AW),
    .NUM_FWD (NUM_FWD),
    .SW      (SW)
  ) u_resolve (
    .rs2_addr  (rs2_addr),
    .rf_data   (rf_data),
    .fwd_valid (fwd_valid),
    .fwd_wen   (fwd_wen),
    .fwd_addr  (fwd_addr),
    .fwd_data  (fwd_data),
    .resolved  (resolved_p0),
    .src       (src_p0),
    .slot0_hit (slot0_hit_p0)
  );

  // Stage p0: decode-side selection and handshake
  // Hazard ignores bsel: a store with an immediate offset still needs rs2.
  assign sel_p0    = opb_sel_e'(bsel);
  assign op_b_p0   = (sel_p0 == OPB_IMM) ? imm : resolved_p0;
  assign hazard_p0 = in_valid & rs2_used & slot0_hit_p0 & fwd_is_load;
  assign in_ready  = ((state_p1 == ST_EMPTY) | out_ready) & ~hazard_p0;
  assign xfer_p0   = in_valid & in_ready;

  // Stage p1: ID/EX register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_p1      <= ST_EMPTY;
      op_b_p1       <= '0;
      store_data_p1 <= '0;
      src_p1        <= '0;
      stall_cnt_p1  <= '0;
    end else begin
      if (hazard_p0 && (stall_cnt_p1 != {CNT_W{1'b1}})) begin
        stall_cnt_p1 <= stall_cnt_p1 + 1'b1;
      end
      if (flush) begin
        state_p1 <= ST_EMPTY;
      end else if (xfer_p0) begin
        state_p1      <= ST_FULL;
        op_b_p1       <= op_b_p0;
        store_data_p1 <= resolved_p0;
        src_p1        <= src_p0;
      end else if (out_ready) begin
        state_p1 <= ST_EMPTY;
      end
    end
  end

  assign out_valid  = (state_p1 == ST_FULL);
  assign op_b       = op_b_p1;
  assign store_data = store_data_p1;
  assign fwd_src    = src_p1;
  assign stall_cnt  = stall_cnt_p1;

endmodule

// File: tb/tb_opb_fwd_sel.sv
// Directed bench for opb_fwd_sel: reset, forwarding priority, load-use stall,
// backpressure, flush and stall-counter saturation (counter narrowed to 3 bits).
module tb_opb_fwd_sel;

  localparam int WIDTH   = 32;
  localparam int AW      = 5;
  localparam int NUM_FWD = 2;
  localparam int CNT_W   = 3;
  localparam int SW      = $clog2(NUM_FWD + 1);

  logic                     clk = 1'b0;
  logic                     rst;
  logic                     in_valid;
  logic                     in_ready;
  logic [AW-1:0]            rs2_addr;
  logic                     rs2_used;
  logic [WIDTH-1:0]         rf_data;
  logic [WIDTH-1:0]         imm;
  logic                     bsel;
  logic [NUM_FWD-1:0]       fwd_valid;
  logic [NUM_FWD-1:0]       fwd_wen;
  logic [NUM_FWD*AW-1:0]    fwd_addr;
  logic [NUM_FWD*WIDTH-1:0] fwd_data;
  logic                     fwd_is_load;
  logic                     flush;
  logic                     out_valid;
  logic                     out_ready;
  logic [WIDTH-1:0]         op_b;
  logic [WIDTH-1:0]         store_data;
  logic [SW-1:0]            fwd_src;
  logic [CNT_W-1:0]         stall_cnt;

  int n_checks = 0;
  int n_errors = 0;

  opb_fwd_sel #(
    .WIDTH   (WIDTH),
    .AW      (AW),
    .NUM_FWD (NUM_FWD),
    .CNT_W   (CNT_W)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .rs2_addr    (rs2_addr),
    .rs2_used    (rs2_used),
    .rf_data     (rf_data),
    .imm         (imm),
    .bsel        (bsel),
    .fwd_valid   (fwd_valid),
    .fwd_wen     (fwd_wen),
    .fwd_addr    (fwd_addr),
    .fwd_data    (fwd_data),
    .fwd_is_load (fwd_is_load),
    .flush       (flush),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .op_b        (op_b),
    .store_data  (store_data),
    .fwd_src     (fwd_src),
    .stall_cnt   (stall_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_in(input logic v, input logic [AW-1:0] a, input logic used,
                        input logic [WIDTH-1:0] rf, input logic [WIDTH-1:0] im,
                        input logic bs);
    in_valid = v;
    rs2_addr = a;
    rs2_used = used;
    rf_data  = rf;
    imm      = im;
    bsel     = bs;
  endtask

  initial begin
    rst = 1'b1;
    set_in(1'b0, '0, 1'b0, '0, '0, 1'b0);
    fwd_valid   = '0;
    fwd_wen     = '0;
    fwd_addr    = '0;
    fwd_data    = '0;
    fwd_is_load = 1'b0;
    flush       = 1'b0;
    out_ready   = 1'b1;
    step();
    step();
    rst = 1'b0;

    // 1: fill the stage, then reset asynchronously mid-cycle
    out_ready = 1'b0;
    set_in(1'b1, 5'd3, 1'b1, 32'h33, 32'h0, 1'b0);
    step();
    chk("pre_rst_valid", 64'(out_valid), 64'd1);
    chk("pre_rst_op_b", 64'(op_b), 64'h33);
    in_valid = 1'b0;
    #2 rst = 1'b1;
    #1;
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_op_b", 64'(op_b), 64'd0);
    chk("rst_store", 64'(store_data), 64'd0);
    chk("rst_src", 64'(fwd_src), 64'd0);
    chk("rst_stall", 64'(stall_cnt), 64'd0);
    chk("rst_in_ready", 64'(in_ready), 64'd1);
    #1 rst = 1'b0;
    out_ready = 1'b1;
    step();

    // 2: register file path, then immediate select
    set_in(1'b1, 5'd5, 1'b1, 32'h5555, 32'h1111, 1'b0);
    step();
    chk("rf_valid", 64'(out_valid), 64'd1);
    chk("rf_op_b", 64'(op_b), 64'h5555);
    chk("rf_store", 64'(store_data), 64'h5555);
    chk("rf_src", 64'(fwd_src), 64'd0);
    bsel = 1'b1;
    step();
    chk("imm_op_b", 64'(op_b), 64'h1111);
    chk("imm_store", 64'(store_data), 64'h5555);

    // 3: priority between slots, and x0
    bsel      = 1'b0;
    fwd_valid = 2'b11;
    fwd_wen   = 2'b11;
    fwd_addr  = {5'd5, 5'd5};
    fwd_data  = {32'hBBBB, 32'hAAAA};
    step();
    chk("prio_op_b", 64'(op_b), 64'hAAAA);
    chk("prio_src", 64'(fwd_src), 64'd1);
    fwd_valid = 2'b10;
    step();
    chk("slot1_op_b", 64'(op_b), 64'hBBBB);
    chk("slot1_src", 64'(fwd_src), 64'd2);
    chk("slot1_store", 64'(store_data), 64'hBBBB);
    rs2_addr  = 5'd0;
    fwd_valid = 2'b11;
    fwd_addr  = {5'd0, 5'd0};
    step();
    chk("x0_op_b", 64'(op_b), 64'd0);
    chk("x0_store", 64'(store_data), 64'd0);
    chk("x0_src", 64'(fwd_src), 64'd0);

    // 4: load-use stall on slot 0, released when the load moves on
    set_in(1'b1, 5'd7, 1'b1, 32'h7777, 32'h0, 1'b1);
    fwd_valid   = 2'b11;
    fwd_addr    = {5'd7, 5'd7};
    fwd_data    = {32'h1234, 32'hDEAD};
    fwd_is_load = 1'b1;
    #1;
    chk("lu_in_ready", 64'(in_ready), 64'd0);
    step();
    chk("lu_out_valid", 64'(out_valid), 64'd0);
    chk("lu_ready_c2", 64'(in_ready), 64'd0);
    step();
    chk("lu_stall_cnt", 64'(stall_cnt), 64'd2);
    fwd_is_load = 1'b0;
    fwd_valid   = 2'b10;
    bsel        = 1'b0;
    #1;
    chk("lu_release_ready", 64'(in_ready), 64'd1);
    step();
    chk("lu_op_b", 64'(op_b), 64'h1234);
    chk("lu_src", 64'(fwd_src), 64'd2);
    chk("lu_stall_hold", 64'(stall_cnt), 64'd2);

    // 5: backpressure holds everything, then back-to-back transfer
    fwd_valid = 2'b00;
    out_ready = 1'b0;
    set_in(1'b1, 5'd9, 1'b1, 32'h9999, 32'h0, 1'b0);
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("bp_in_ready", 64'(in_ready), 64'd0);
      step();
      chk("bp_valid", 64'(out_valid), 64'd1);
      chk("bp_op_b", 64'(op_b), 64'h1234);
      chk("bp_src", 64'(fwd_src), 64'd2);
    end
    out_ready = 1'b1;
    #1;
    chk("b2b_in_ready", 64'(in_ready), 64'd1);
    step();
    chk("b2b_valid", 64'(out_valid), 64'd1);
    chk("b2b_op_b", 64'(op_b), 64'h9999);
    chk("b2b_src", 64'(fwd_src), 64'd0);
    in_valid = 1'b0;
    step();
    chk("drain_valid", 64'(out_valid), 64'd0);

    // 6: flush discards a simultaneous transfer
    set_in(1'b1, 5'd10, 1'b1, 32'hF00D, 32'h0, 1'b0);
    flush = 1'b1;
    step();
    chk("flush_valid", 64'(out_valid), 64'd0);
    chk("flush_op_b", 64'(op_b), 64'h9999);
    flush    = 1'b0;
    in_valid = 1'b0;
    step();
    chk("flush_after", 64'(out_valid), 64'd0);

    // flush during a hazard still counts, then the counter saturates
    set_in(1'b1, 5'd7, 1'b1, 32'h0, 32'h0, 1'b0);
    fwd_valid   = 2'b01;
    fwd_wen     = 2'b01;
    fwd_addr    = {5'd0, 5'd7};
    fwd_is_load = 1'b1;
    flush       = 1'b1;
    step();
    chk("flush_stall_cnt", 64'(stall_cnt), 64'd3);
    flush = 1'b0;
    for (int i = 0; i < 6; i++) step();
    chk("sat_stall_cnt", 64'(stall_cnt), 64'd7);
    chk("sat_out_valid", 64'(out_valid), 64'd0);
    in_valid    = 1'b0;
    fwd_is_load = 1'b0;
    step();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
